ntt_stage_sched: RTL

- Sequences one full 256-point forward or inverse NTT over the 8-butterfly-unit array, layer by layer.
- Per layer it issues the butterfly read beats that drive address generation and bank decode, and supplies the layer's olen.
- It delays read beats by the fixed read-plus-butterfly pipeline latency to produce matching write beats.
- It drains the pipeline before starting the next layer, so no layer reads a coefficient before the previous layer has written it.

---
 rtl/ntt_stage_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ntt_stage_sched.sv
// Purpose: layer sequencer for a 256-point forward/inverse NTT on an 8-BU array; issues read beats, delays them into write beats.
// Latency: first read beat one cycle after an accepted start; done_o pulses NUM_STAGES*(BEATS+PIPE_LAT)+1 cycles after it.
// Backpressure: none; once started the schedule runs to completion, and start_i outside IDLE is dropped.
//
// Ports:
//   clk_i, rst_i (async, active-low)     clock / reset
//   start_i, is_ntt_i                    start request and direction (1 = forward), sampled in IDLE
//   busy_o, is_ntt_o, stage_o, olen_o    run status, latched direction, current layer and its half-span
//   rd_en_o, rd_beat_o                   read beat strobe / index within the layer
//   wr_en_o, wr_beat_o                   read beat delayed by PIPE_LAT
//   done_o                               single-cycle completion pulse
module ntt_stage_sched #(
  parameter int N          = 256,
  parameter int N_BU       = 8,
  parameter int NUM_STAGES = 7,
  parameter int PIPE_LAT   = 6,
  parameter int BEAT_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              is_ntt_i,
  output logic              busy_o,
  output logic              is_ntt_o,
  output logic [2:0]        stage_o,
  output logic [7:0]        olen_o,
  output logic              rd_en_o,
  output logic [BEAT_W-1:0] rd_beat_o,
  output logic              wr_en_o,
  output logic [BEAT_W-1:0] wr_beat_o,
  output logic              done_o
);

  localparam int BEATS  = N / (2 * N_BU);
  localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PIPE_LAT - 1);
  localparam logic [2:0]        STAGE_LAST = 3'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                          state_q, state_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic [DCNT_W-1:0]               dcnt_q, dcnt_d;
  logic [2:0]                      stage_q, stage_d;
  logic [7:0]                      olen_q, olen_d;
  logic                            is_ntt_q, is_ntt_d;
  logic [PIPE_LAT-1:0]             wen_pipe_q, wen_pipe_d;
  logic [PIPE_LAT-1:0][BEAT_W-1:0] wbeat_pipe_q, wbeat_pipe_d;

  logic rd_en;
  logic done;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    dcnt_d   = dcnt_q;
    stage_d  = stage_q;
    olen_d   = olen_q;
    is_ntt_d = is_ntt_q;
    rd_en    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          is_ntt_d = is_ntt_i;
          stage_d  = 3'd0;
          beat_d   = '0;
          olen_d   = is_ntt_i ? 8'(N / 2) : 8'd2;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        // Last write beat of the layer leaves the delay line in the final DRAIN cycle.
        if (dcnt_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = FINISH;
          end else begin
            stage_d = stage_q + 3'd1;
            // Forward halves the span each layer, inverse doubles it.
            olen_d  = is_ntt_q ? (olen_q >> 1) : (olen_q << 1);
            state_d = ISSUE;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Delay line shifts unconditionally so in-flight writes always complete.
  always_comb begin
    wen_pipe_d      = wen_pipe_q;
    wbeat_pipe_d    = wbeat_pipe_q;
    wen_pipe_d[0]   = rd_en;
    wbeat_pipe_d[0] = rd_en ? beat_q : '0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wen_pipe_d[i]   = wen_pipe_q[i-1];
      wbeat_pipe_d[i] = wbeat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      dcnt_q       <= '0;
      stage_q      <= 3'd0;
      olen_q       <= 8'd0;
      is_ntt_q     <= 1'b0;
      wen_pipe_q   <= '0;
      wbeat_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      dcnt_q       <= dcnt_d;
      stage_q      <= stage_d;
      olen_q       <= olen_d;
      is_ntt_q     <= is_ntt_d;
      wen_pipe_q   <= wen_pipe_d;
      wbeat_pipe_q <= wbeat_pipe_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign is_ntt_o  = is_ntt_q;
  assign stage_o   = stage_q;
  assign olen_o    = olen_q;
  assign rd_en_o   = rd_en;
  assign rd_beat_o = rd_en ? beat_q : '0;
  assign wr_en_o   = wen_pipe_q[PIPE_LAT-1];
  assign wr_beat_o = wbeat_pipe_q[PIPE_LAT-1];
  assign done_o    = done;

endmodule
